name_decoder: RTL and testbench
===============================

NAME_DECODER -- requirements
Module: name_decoder

Interface
REQ-001 Parameter MAXLEN, default 6: maximum token length in characters.
REQ-002 Parameter TS_W, default 8: timestamp counter width in bits.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  in_char holds a valid character.
REQ-006 in_char  input  8  ASCII character.
REQ-007 in_ready  output  1  block accepts in_char this cycle.
REQ-008 out_valid  output  1  decoded result available.
REQ-009 out_ready  input  1  downstream accepts the result.
REQ-010 out_id  output  3  token id: 0 unknown, 1 INTEL, 2 AMD, 3 APPLE, 4 LENOVO, 5 HP, 7 overflow.
REQ-011 out_len  output  3  number of characters in the token, saturating at MAXLEN.
REQ-012 out_ts  output  TS_W  timestamp counter value captured when the token's first character was accepted.

Function
REQ-013 A character SHALL be accepted in a cycle only when in_valid=1 and in_ready=1.
REQ-014 in_ready SHALL be 1 in every state except EMIT, and 0 in EMIT.
REQ-015 Delimiters SHALL be 0x20 (space) and 0x0A (newline); every other byte is a token character.
REQ-016 Lowercase letters 0x61-0x7A SHALL be converted to uppercase before storage and matching.
REQ-017 FSM states SHALL be IDLE, COLLECT, DISCARD and EMIT, with reset state IDLE.
REQ-018 IDLE, on an accepted non-delimiter: store it as character 0, set len=1, capture ts, go to COLLECT.
REQ-019 IDLE, on an accepted delimiter: stay in IDLE and emit nothing (empty tokens are ignored).
REQ-020 COLLECT, on an accepted non-delimiter with len<MAXLEN: store it at index len and increment len.
REQ-021 COLLECT, on an accepted non-delimiter with len==MAXLEN: go to DISCARD and mark the token as overflow.
REQ-022 COLLECT, on an accepted delimiter: compare the buffer against the five names (exact length and content), latch id, len and ts, then go to EMIT.
REQ-023 DISCARD SHALL drop all non-delimiters; on a delimiter it latches id=7 and len=MAXLEN, then goes to EMIT.
REQ-024 Latency: a delimiter accepted at cycle N SHALL make out_valid=1 at cycle N+1.
REQ-025 EMIT: out_valid=1 and out_id/out_len/out_ts SHALL hold stable until out_valid and out_ready are both 1.
REQ-026 On that handshake the FSM SHALL go to IDLE; in_ready rises the following cycle.
REQ-027 out_valid=1 with out_ready=1 in the first EMIT cycle SHALL complete in that one cycle.
REQ-028 A prefix or extension of a name SHALL decode to id 0 (e.g. "AM", "HPX").
REQ-029 The timestamp counter SHALL free-run, incrementing by 1 every cycle from 0 after reset.
REQ-030 The timestamp counter SHALL wrap modulo 2^TS_W with no flag.
REQ-031 A token whose characters span a timestamp wrap SHALL report the pre-wrap capture value.
REQ-032 in_valid=0 SHALL stall the FSM in its current state with no timeout.

Reset
REQ-033 While rst_n=0, the block SHALL be forced asynchronously to: state IDLE, in_ready=1, out_valid=0, out_id=0, out_len=0, out_ts=0, timestamp=0, len=0.
REQ-034 rst_n asserted mid-token or in EMIT SHALL discard the partial token or pending result without emitting it.
REQ-035 The first character SHALL be accepted on the first posedge after rst_n deasserts.

Verification
REQ-036 Reset release, then "INTEL\n" one character per cycle with out_ready=1 -> exactly one result: out_id=1, out_len=5, out_ts=0, out_valid for 1 cycle.
REQ-037 "amd Apple lenovo hp\n" -> results 2/3, 3/5, 4/6, 5/2 (id/len) in order; no result for delimiters.
REQ-038 "LENOVOX " -> out_id=7, out_len=6; the next token "HP " -> out_id=5.
REQ-039 "AM " and "  " (double space) -> a single result, out_id=0, out_len=2; the empty token produces nothing.
REQ-040 "HP " with out_ready=0 for 10 cycles -> out_valid and outputs stable; in_ready=0 throughout; "AMD " after release -> out_id=2.
REQ-041 rst_n pulsed low after "APP" -> no result; "HP " after release -> out_id=5, out_ts = cycle count since release.

Source files
------------

// File: rtl/name_decoder.sv
// Name decoder: assembles a token from a stream of ASCII characters,
// matches it against five vendor names and reports id, length and the
// timestamp of the token's first character through a valid/ready port.
module name_decoder #(
  parameter int MAXLEN = 6,
  parameter int TS_W   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [7:0]      in_char,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_id,
  output logic [2:0]      out_len,
  output logic [TS_W-1:0] out_ts
);

  typedef enum logic [1:0] {IDLE, COLLECT, DISCARD, EMIT} state_t;

  // out_len is 3 bits wide, so a token longer than 7 characters cannot be reported.
  localparam logic [2:0] LEN_MAX = 3'(MAXLEN);

  // Names stored with character 0 in the least significant byte.
  localparam logic [55:0] NAME_INTEL  = {16'h0, "L", "E", "T", "N", "I"};
  localparam logic [55:0] NAME_AMD    = {32'h0, "D", "M", "A"};
  localparam logic [55:0] NAME_APPLE  = {16'h0, "E", "L", "P", "P", "A"};
  localparam logic [55:0] NAME_LENOVO = {8'h0, "O", "V", "O", "N", "E", "L"};
  localparam logic [55:0] NAME_HP     = {40'h0, "P", "H"};

  state_t          r_state;
  logic [7:0]      r_buf [MAXLEN];
  logic [2:0]      r_len;
  logic [TS_W-1:0] r_ts;
  logic [TS_W-1:0] r_tokTs;
  logic            r_inReady;
  logic            r_outValid;
  logic [2:0]      r_outId;
  logic [2:0]      r_outLen;
  logic [TS_W-1:0] r_outTs;

  logic            w_accept;
  logic            w_isDelim;
  logic [7:0]      w_upper;
  logic [55:0]     w_word;
  logic [2:0]      w_matchId;

  assign w_accept  = in_valid && r_inReady;
  assign w_isDelim = (in_char == 8'h20) || (in_char == 8'h0A);
  assign w_upper   = ((in_char >= 8'h61) && (in_char <= 8'h7A)) ? (in_char - 8'h20) : in_char;

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign out_id    = r_outId;
  assign out_len   = r_outLen;
  assign out_ts    = r_outTs;

  // Exact match: same length and the first nlen characters equal; bytes
  // beyond the current length may hold stale data and are masked off.
  function automatic logic matchName(input logic [55:0] word, input logic [2:0] len,
                                     input logic [55:0] name, input logic [2:0] nlen);
    logic [55:0] mask;
    mask = '0;
    for (int i = 0; i < 7; i++) begin
      if (i < int'(nlen)) mask[8*i +: 8] = 8'hFF;
    end
    return (len == nlen) && ((word & mask) == name);
  endfunction

  // Flatten the character buffer into one word for comparison.
  always_comb begin
    w_word = '0;
    for (int i = 0; i < MAXLEN; i++) w_word[8*i +: 8] = r_buf[i];
  end

  // Look up the buffered token among the known names; 0 when nothing matches.
  always_comb begin
    w_matchId = 3'd0;
    if (matchName(w_word, r_len, NAME_INTEL, 3'd5))       w_matchId = 3'd1;
    else if (matchName(w_word, r_len, NAME_AMD, 3'd3))    w_matchId = 3'd2;
    else if (matchName(w_word, r_len, NAME_APPLE, 3'd5))  w_matchId = 3'd3;
    else if (matchName(w_word, r_len, NAME_LENOVO, 3'd6)) w_matchId = 3'd4;
    else if (matchName(w_word, r_len, NAME_HP, 3'd2))     w_matchId = 3'd5;
  end

  // Free-running timestamp, wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ts <= '0;
    else        r_ts <= r_ts + 1'b1;
  end

  // Token FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_tokTs    <= '0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_outId    <= '0;
      r_outLen   <= '0;
      r_outTs    <= '0;
      for (int i = 0; i < MAXLEN; i++) r_buf[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept && !w_isDelim) begin
            r_buf[0] <= w_upper;
            r_len    <= 3'd1;
            r_tokTs  <= r_ts;
            r_state  <= COLLECT;
          end
        end
        COLLECT: begin
          if (w_accept) begin
            if (w_isDelim) begin
              r_outId    <= w_matchId;
              r_outLen   <= r_len;
              r_outTs    <= r_tokTs;
              r_outValid <= 1'b1;
              r_inReady  <= 1'b0;
              r_state    <= EMIT;
            end else if (r_len < LEN_MAX) begin
              r_buf[r_len] <= w_upper;
              r_len        <= r_len + 3'd1;
            end else begin
              r_state <= DISCARD;
            end
          end
        end
        DISCARD: begin
          if (w_accept && w_isDelim) begin
            r_outId    <= 3'd7;
            r_outLen   <= LEN_MAX;
            r_outTs    <= r_tokTs;
            r_outValid <= 1'b1;
            r_inReady  <= 1'b0;
            r_state    <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_len      <= '0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_name_decoder.sv
// Scoreboard bench for name_decoder: the driver feeds characters and a
// string-level reference model pushes expected results; a negedge monitor
// pops and compares on every output handshake.
module tb_name_decoder;

  localparam int MAXLEN = 6;
  localparam int TS_W   = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            in_valid = 1'b0;
  logic [7:0]      in_char = 8'h00;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [2:0]      out_id;
  logic [2:0]      out_len;
  logic [TS_W-1:0] out_ts;

  name_decoder #(.MAXLEN(MAXLEN), .TS_W(TS_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_char(in_char),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_len(out_len), .out_ts(out_ts)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int len;
    int ts;
  } exp_t;

  exp_t  expQ[$];
  int    checkCount = 0;
  int    errCount = 0;
  int    cycleCount = 0;
  int    readyMode = 0;
  string tok = "";
  bit    tokActive = 0;
  bit    tokOvf = 0;
  int    tokTs = 0;

  bit         holdValid = 0;
  logic [2:0] holdId;
  logic [2:0] holdLen;
  logic [TS_W-1:0] holdTs;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int nameId(input string s);
    if (s == "INTEL")  return 1;
    if (s == "AMD")    return 2;
    if (s == "APPLE")  return 3;
    if (s == "LENOVO") return 4;
    if (s == "HP")     return 5;
    return 0;
  endfunction

  // Reference model: whole-token view of the character stream.
  task automatic modelFeed(input byte c, input int ts);
    byte u;
    if (c == 8'h20 || c == 8'h0A) begin
      if (tokOvf)         expQ.push_back('{id: 7, len: MAXLEN, ts: tokTs});
      else if (tokActive) expQ.push_back('{id: nameId(tok), len: tok.len(), ts: tokTs});
      tokActive = 0;
      tokOvf = 0;
      tok = "";
    end else begin
      u = c;
      if (u >= "a" && u <= "z") u = u - 8'd32;
      if (!tokActive && !tokOvf) begin
        tokActive = 1;
        tokTs = ts % (1 << TS_W);
        tok = $sformatf("%c", u);
      end else if (tokActive) begin
        if (tok.len() == MAXLEN) begin
          tokOvf = 1;
          tokActive = 0;
        end else begin
          tok = $sformatf("%s%c", tok, u);
        end
      end
    end
  endtask

  task automatic driveReady();
    case (readyMode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
    cycleCount++;
    driveReady();
  endtask

  task automatic idleCycles(input int n);
    in_valid = 1'b0;
    repeat (n) stepCycle();
  endtask

  // Present one character and hold it until the DUT accepts it (bounded).
  task automatic applyStimulus(input byte c);
    int waited = 0;
    in_valid = 1'b1;
    in_char = c;
    while (!in_ready && waited < 100) begin
      stepCycle();
      waited++;
    end
    checkOutput("accept_within_bound", 32'(in_ready), 32'd1);
    if (in_ready) begin
      modelFeed(c, cycleCount);
      stepCycle();
    end
    in_valid = 1'b0;
  endtask

  task automatic sendString(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
      applyStimulus(s[i]);
    end
  endtask

  // Called just after a posedge; asserts reset, checks the async values, releases.
  task automatic doReset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    expQ.delete();
    tok = "";
    tokActive = 0;
    tokOvf = 0;
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_id", 32'(out_id), 32'd0);
    checkOutput("reset_out_len", 32'(out_len), 32'd0);
    checkOutput("reset_out_ts", 32'(out_ts), 32'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycleCount = 0;
    driveReady();
  endtask

  // Monitor: handshake results against the scoreboard, stability while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      holdValid = 0;
    end else begin
      checkOutput("in_ready_vs_out_valid", 32'(in_ready), 32'(!out_valid));
      if (holdValid) begin
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_id", 32'(out_id), 32'(holdId));
        checkOutput("hold_len", 32'(out_len), 32'(holdLen));
        checkOutput("hold_ts", 32'(out_ts), 32'(holdTs));
      end
      holdValid = 0;
      if (out_valid) begin
        if (out_ready) begin
          if (expQ.size() == 0) begin
            checkCount++;
            errCount++;
            $display("[TB] FAIL unexpected_result actual id=%0d len=%0d required none", out_id, out_len);
          end else begin
            e = expQ.pop_front();
            checkOutput("result_id", 32'(out_id), 32'(e.id));
            checkOutput("result_len", 32'(out_len), 32'(e.len));
            checkOutput("result_ts", 32'(out_ts), 32'(e.ts));
          end
        end else begin
          holdValid = 1;
          holdId = out_id;
          holdLen = out_len;
          holdTs = out_ts;
        end
      end
    end
  end

  string words[13] = '{"intel", "AMD", "apple", "LeNoVo", "hp", "AM", "HPX",
                       "INTELX", "LENOVOXYZ", "A", "Q9", "APPLES", "X"};

  initial begin
    string w;
    byte   c;
    int    waited;

    @(posedge clk);
    #1;
    readyMode = 0;
    doReset();

    sendString("INTEL\n", 0);
    idleCycles(3);
    sendString("amd Apple lenovo hp\n", 0);
    idleCycles(2);
    sendString("LENOVOX ", 0);
    sendString("HP ", 0);
    idleCycles(2);
    sendString("AM ", 0);
    sendString("  ", 0);
    idleCycles(3);

    readyMode = 1;
    driveReady();
    sendString("HP ", 0);
    idleCycles(10);
    checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
    checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
    readyMode = 0;
    driveReady();
    sendString("AMD ", 0);
    idleCycles(3);

    sendString("APP", 0);
    doReset();
    idleCycles(5);
    sendString("HP ", 0);
    idleCycles(3);

    readyMode = 2;
    for (int t = 0; t < 150; t++) begin
      w = words[$urandom_range(0, 12)];
      for (int i = 0; i < w.len(); i++) begin
        c = w[i];
        if (c >= "A" && c <= "Z" && $urandom_range(0, 1) == 1) c = c | 8'h20;
        if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
        applyStimulus(c);
      end
      applyStimulus(($urandom_range(0, 1) == 1) ? 8'h20 : 8'h0A);
      if ($urandom_range(0, 4) == 0) applyStimulus(8'h20);
      if ($urandom_range(0, 39) == 0) doReset();
    end

    readyMode = 0;
    driveReady();
    in_valid = 1'b0;
    waited = 0;
    while (expQ.size() > 0 && waited < 50) begin
      stepCycle();
      waited++;
    end
    stepCycle();
    checkOutput("drain_queue_empty", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, errCount);
    $finish;
  end

endmodule
